// File: rtl/otter_io_pkg.sv
// Shared register map, CTRL bit positions and state encoding for the OTTER IO timer.
package otter_io_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_LOAD     = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_PRESCALE = 5'h10;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

  // The window is 32 bytes wide; only word-aligned accesses decode.
  function automatic logic addr_hit(input logic [26:0] addr_hi,
                                    input logic [1:0]  addr_lo,
                                    input logic [26:0] base_hi);
    return (addr_hi == base_hi) && (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/otter_io_timer_if.sv
// IOBUS connection between the MCU (master) and a memory-mapped peripheral (slave).
interface otter_io_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/otter_io_timer_prescaler.sv
// Free-running prescaler: counts 0..limit while enabled and ticks on the limit cycle.
module io_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] limit,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_r;
  logic             at_limit_s;

  assign at_limit_s = (cnt_r == limit);
  assign tick       = enable && at_limit_s;

  // Clear has priority so a reload or restart always begins a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (at_limit_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped down-counting timer on the OTTER IOBUS with prescaler,
// optional auto-reload and a one-cycle interrupt pulse on expiry.
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          PRE_W     = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  otter_io_timer_if.slave bus,
  output logic            INTR
);

  timer_state_e     state_r;
  logic             auto_r;
  logic             ie_r;
  logic [31:0]      load_r;
  logic [31:0]      count_r;
  logic [PRE_W-1:0] prescale_r;
  logic             exp_r;
  logic             intr_r;
  logic [31:0]      rd_data_r;

  logic        hit_s;
  logic [4:0]  off_s;
  logic [31:0] wdata_s;
  logic        wr_ctrl_s;
  logic        wr_load_s;
  logic        wr_status_s;
  logic        wr_pre_s;
  logic        run_s;
  logic        tick_s;
  logic        pre_clear_s;
  logic        expire_s;
  logic [31:0] rd_mux_s;

  assign hit_s       = addr_hit(bus.IOBUS_ADDR[31:5], bus.IOBUS_ADDR[1:0], BASE_ADDR[31:5]);
  assign off_s       = {bus.IOBUS_ADDR[4:2], 2'b00};
  assign wdata_s     = bus.IOBUS_OUT;
  assign wr_ctrl_s   = bus.IOBUS_WR && hit_s && (off_s == OFF_CTRL);
  assign wr_load_s   = bus.IOBUS_WR && hit_s && (off_s == OFF_LOAD);
  assign wr_status_s = bus.IOBUS_WR && hit_s && (off_s == OFF_STATUS);
  assign wr_pre_s    = bus.IOBUS_WR && hit_s && (off_s == OFF_PRESCALE);

  assign run_s       = (state_r == ST_RUN);
  assign pre_clear_s = wr_load_s || (wr_ctrl_s && wdata_s[CTRL_EN]);
  // A LOAD write on the same edge replaces the count, so that tick cannot expire.
  assign expire_s    = tick_s && (count_r == 32'd0) && !wr_load_s;

  io_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk    (CLK),
    .reset  (RESET),
    .clear  (pre_clear_s),
    .enable (run_s),
    .limit  (prescale_r),
    .tick   (tick_s)
  );

  // Run/idle state and CTRL mode bits; a CTRL write overrides a one-shot stop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      auto_r  <= 1'b0;
      ie_r    <= 1'b0;
    end else if (wr_ctrl_s) begin
      state_r <= wdata_s[CTRL_EN] ? ST_RUN : ST_IDLE;
      auto_r  <= wdata_s[CTRL_AUTO];
      ie_r    <= wdata_s[CTRL_IE];
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_RUN:  state_r <= (expire_s && !auto_r) ? ST_IDLE : ST_RUN;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Counter datapath, expiry flag and interrupt pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      load_r     <= 32'd0;
      count_r    <= 32'd0;
      prescale_r <= '0;
      exp_r      <= 1'b0;
      intr_r     <= 1'b0;
    end else begin
      if (wr_load_s) begin
        load_r  <= wdata_s;
        count_r <= wdata_s;
      end else if (tick_s) begin
        if (count_r != 32'd0) begin
          count_r <= count_r - 32'd1;
        end else if (auto_r) begin
          count_r <= load_r;
        end
      end
      if (wr_pre_s) begin
        prescale_r <= wdata_s[PRE_W-1:0];
      end
      // A new expiry outranks a simultaneous write-1-to-clear.
      if (expire_s) begin
        exp_r <= 1'b1;
      end else if (wr_status_s && wdata_s[0]) begin
        exp_r <= 1'b0;
      end
      intr_r <= expire_s && ie_r;
    end
  end

  // Read mux for the address on the bus this cycle; misses and unused slots read 0.
  always_comb begin
    rd_mux_s = 32'd0;
    if (hit_s) begin
      case (off_s)
        OFF_CTRL:     rd_mux_s = {29'd0, ie_r, auto_r, run_s};
        OFF_LOAD:     rd_mux_s = load_r;
        OFF_COUNT:    rd_mux_s = count_r;
        OFF_STATUS:   rd_mux_s = {31'd0, exp_r};
        OFF_PRESCALE: rd_mux_s = 32'(prescale_r);
        default:      rd_mux_s = 32'd0;
      endcase
    end else begin
      rd_mux_s = 32'd0;
    end
  end

  // Read data is returned one cycle after the address.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_r <= 32'd0;
    end else begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign bus.IOBUS_IN = rd_data_r;
  assign INTR         = intr_r;

endmodule

// File: tb/tb_otter_io_timer.sv
// Scoreboard bench for otter_io_timer: stimulus queues expected read data and
// INTR cycles, an independent monitor compares them as the DUT presents them.
module tb_otter_io_timer;

  localparam logic [31:0] BASE   = 32'h1100_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_LOAD = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_PRE  = BASE + 32'h10;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_item_t;

  logic clk;
  logic rst;
  logic intr;
  logic rd_req  = 1'b0;
  logic rd_seen = 1'b0;
  logic done    = 1'b0;
  logic drained = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   t;
  int   exp_c;
  rd_item_t rd_q[$];
  rd_item_t rd_cur;
  int   intr_q[$];

  otter_io_timer_if bus ();

  otter_io_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .INTR  (intr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= rd_req;
  end

  // Monitor: read responses, INTR pulses and the final drain check.
  always @(negedge clk) begin
    if (rd_seen) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unqueued: IOBUS_IN=%h, no read expected", bus.IOBUS_IN);
      end else begin
        rd_cur = rd_q.pop_front();
        if (bus.IOBUS_IN !== rd_cur.exp) begin
          n_err++;
          $display("FAIL %s: IOBUS_IN=%h expected %h (cycle %0d)",
                   rd_cur.name, bus.IOBUS_IN, rd_cur.exp, cyc);
        end
      end
    end
    if (intr !== 1'b0) begin
      n_cmp++;
      if (intr_q.size() == 0) begin
        n_err++;
        $display("FAIL intr_unexpected: INTR=%b at cycle %0d, expected 0", intr, cyc);
      end else begin
        exp_c = intr_q.pop_front();
        if (exp_c != cyc) begin
          n_err++;
          $display("FAIL intr_time: INTR at cycle %0d expected at cycle %0d", cyc, exp_c);
        end
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      n_cmp++;
      if (intr_q.size() != 0 || rd_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: %0d INTR pulses and %0d reads outstanding, expected 0 and 0",
                 intr_q.size(), rd_q.size());
      end
    end
  end

  function automatic void expect_rd(input logic [31:0] exp, input string name);
    rd_item_t it;
    it.exp  = exp;
    it.name = name;
    rd_q.push_back(it);
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_OUT  = data;
    bus.IOBUS_WR   = 1'b1;
    rd_req         = 1'b0;
    @(negedge clk);
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_WR   = 1'b0;
    rd_req         = 1'b1;
    expect_rd(exp, name);
    @(negedge clk);
    rd_req         = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.IOBUS_ADDR = 32'h0000_0000;
    bus.IOBUS_WR   = 1'b0;
    rd_req         = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    bus.IOBUS_ADDR = 32'h0000_0000;
    bus.IOBUS_OUT  = 32'h0000_0000;
    bus.IOBUS_WR   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_LOAD, 32'h0, "rst_load");
    rd(A_CNT,  32'h0, "rst_count");
    rd(A_STAT, 32'h0, "rst_status");
    rd(A_PRE,  32'h0, "rst_prescale");

    // One-shot: LOAD=3, PRESCALE=0, CTRL=EN|IE
    wr(A_LOAD, 32'd3);
    wr(A_PRE,  32'd0);
    wr(A_CTRL, 32'h5);
    t = cyc;
    intr_q.push_back(t + 4);
    rd(A_CNT,  32'd3, "os_count3");
    rd(A_CNT,  32'd2, "os_count2");
    rd(A_CNT,  32'd1, "os_count1");
    rd(A_CNT,  32'd0, "os_count0");
    rd(A_STAT, 32'h1, "os_exp_set");
    rd(A_CTRL, 32'h4, "os_en_cleared");
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h0, "os_exp_cleared");

    // Auto-reload: LOAD=1, PRESCALE=2 -> expiry every 6 cycles
    wr(A_LOAD, 32'd1);
    wr(A_PRE,  32'd2);
    wr(A_CTRL, 32'h7);
    t = cyc;
    intr_q.push_back(t + 6);
    intr_q.push_back(t + 12);
    rd(A_CNT, 32'd1, "ar_count_a");
    idle(2);
    rd(A_CNT, 32'd0, "ar_count_b");
    idle(2);
    rd(A_CNT, 32'd1, "ar_count_c");
    idle(2);
    rd(A_CNT, 32'd0, "ar_count_d");
    // W1C on the expiry edge leaves EXP set; a later W1C alone clears it
    wr(A_STAT, 32'h1);
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h1, "w1c_vs_expiry");
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h0, "w1c_alone");
    wr(A_CTRL, 32'h0);

    // Unmapped slot, outside window, misaligned and read-only accesses
    rd(BASE + 32'h14, 32'h0, "rd_slot_14");
    rd(BASE + 32'h20, 32'h0, "rd_outside_20");
    rd(BASE + 32'h05, 32'h0, "rd_misaligned");
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(BASE + 32'h05, 32'hFFFF_FFFF);
    wr(BASE + 32'h08, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'h0, "miss_ctrl");
    rd(A_LOAD, 32'd1, "miss_load");
    rd(A_CNT,  32'd0, "miss_count");
    rd(A_STAT, 32'h0, "miss_status");
    rd(A_PRE,  32'd2, "miss_prescale");
    wr(A_PRE,  32'hABCD_1234);
    rd(A_PRE,  32'h0000_1234, "prescale_zext");

    // Reset mid-count at COUNT=5, together with a LOAD write and a read
    wr(A_LOAD, 32'd9);
    wr(A_PRE,  32'd0);
    wr(A_CTRL, 32'h7);
    idle(4);
    rd(A_CNT, 32'd5, "pre_reset_count");
    rst            = 1'b1;
    bus.IOBUS_ADDR = A_LOAD;
    bus.IOBUS_OUT  = 32'h0000_0055;
    bus.IOBUS_WR   = 1'b1;
    rd_req         = 1'b1;
    expect_rd(32'h0, "reset_iobus_in");
    @(negedge clk);
    rst            = 1'b0;
    bus.IOBUS_WR   = 1'b0;
    rd_req         = 1'b0;
    rd(A_CTRL, 32'h0, "mr_ctrl");
    rd(A_LOAD, 32'h0, "mr_load");
    rd(A_CNT,  32'h0, "mr_count");
    rd(A_STAT, 32'h0, "mr_status");
    rd(A_PRE,  32'h0, "mr_prescale");
    idle(10);

    // IE=0, LOAD=0: expires on the first tick, no INTR
    wr(A_CTRL, 32'h1);
    idle(1);
    rd(A_STAT, 32'h1, "noie_exp");
    rd(A_CTRL, 32'h0, "noie_ctrl");
    rd(A_CNT,  32'h0, "noie_count");
    idle(3);

    // LOAD write on the tick that would expire: load wins, no expiry
    wr(A_STAT, 32'h1);
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h3);
    idle(2);
    wr(A_LOAD, 32'd7);
    rd(A_CNT,  32'd7, "ldtick_count");
    rd(A_STAT, 32'h0, "ldtick_no_exp");
    wr(A_CTRL, 32'h0);

    // CTRL write on the expiry edge: written CTRL wins, EXP and INTR still occur
    wr(A_STAT, 32'h1);
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h5);
    t = cyc;
    intr_q.push_back(t + 2);
    idle(1);
    wr(A_CTRL, 32'h3);
    rd(A_CTRL, 32'h3, "ctrlexp_ctrl");
    rd(A_STAT, 32'h1, "ctrlexp_exp");
    wr(A_CTRL, 32'h0);

    idle(3);
    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
